esc_pwm_bank: RTL and testbench

ESC_PWM_BANK -- requirements
Module: esc_pwm_bank

---
 rtl/esc_pkg.sv | 31 +++
 rtl/esc_pwm_chan.sv | 49 ++++
 rtl/esc_pwm_bank.sv | 109 ++++++++++
 tb/tb_esc_pwm_bank.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/esc_pkg.sv
// Shared defaults and helpers for the ESC PWM bank.
// Pulse width math lives here so every channel agrees on it.
package esc_pkg;

  localparam int unsigned DEF_NUM_CH         = 4;
  localparam int unsigned DEF_SPD_W          = 11;
  localparam int unsigned DEF_MIN_CYC        = 6250;
  localparam int unsigned DEF_SCALE          = 3;
  localparam int unsigned DEF_MAX_SPD        = 2000;
  localparam int unsigned DEF_FRAME_CYC      = 20000;
  localparam int unsigned DEF_TIMEOUT_FRAMES = 50;

  function automatic int unsigned cnt_w(
    input int unsigned n
  );
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int unsigned pulse_w(
    input int unsigned spd,
    input int unsigned min_cyc,
    input int unsigned scale,
    input int unsigned max_spd,
    input logic        force_min
  );
    int unsigned s;
    s = (spd > max_spd) ? max_spd : spd;
    return force_min ? min_cyc : min_cyc + scale * s;
  endfunction

endpackage

// File: rtl/esc_pwm_chan.sv
// One ESC output: holds the frame's speed and compares the
// next counter value against the clamped, scaled width.
module esc_pwm_chan
  import esc_pkg::*;
#(
  parameter int unsigned SPD_W   = DEF_SPD_W,
  parameter int unsigned MIN_CYC = DEF_MIN_CYC,
  parameter int unsigned SCALE   = DEF_SCALE,
  parameter int unsigned MAX_SPD = DEF_MAX_SPD,
  parameter int unsigned CW      = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             force_in,
  input  logic [SPD_W-1:0] spd_in,
  input  logic [CW-1:0]    cnt_nxt,
  output logic             pwm
);

  logic [SPD_W-1:0] spd_q;
  logic             force_q;
  logic [SPD_W-1:0] spd_use;
  logic             force_use;
  int unsigned      width;

  // At a wrap the new frame's values must already drive the compare.
  always_comb begin
    spd_use   = load ? spd_in : spd_q;
    force_use = load ? force_in : force_q;
    width     = pulse_w(32'(spd_use), MIN_CYC, SCALE,
                        MAX_SPD, force_use);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      spd_q   <= '0;
      force_q <= 1'b0;
      pwm     <= 1'b0;
    end else begin
      if (load) begin
        spd_q   <= spd_in;
        force_q <= force_in;
      end
      pwm <= (32'(cnt_nxt) < width);
    end
  end

endmodule

// File: rtl/esc_pwm_bank.sv
// Multi-channel ESC PWM generator: frame timing, arm sampling and
// command timeout here; per-channel pulse shaping in esc_pwm_chan.
module esc_pwm_bank
  import esc_pkg::*;
#(
  parameter int unsigned NUM_CH         = DEF_NUM_CH,
  parameter int unsigned SPD_W          = DEF_SPD_W,
  parameter int unsigned MIN_CYC        = DEF_MIN_CYC,
  parameter int unsigned SCALE          = DEF_SCALE,
  parameter int unsigned MAX_SPD        = DEF_MAX_SPD,
  parameter int unsigned FRAME_CYC      = DEF_FRAME_CYC,
  parameter int unsigned TIMEOUT_FRAMES = DEF_TIMEOUT_FRAMES
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    wrt,
  input  logic [NUM_CH*SPD_W-1:0] speed,
  input  logic                    arm,
  output logic [NUM_CH-1:0]       pwm,
  output logic                    frame_start,
  output logic                    fault
);

  localparam int unsigned CW = cnt_w(FRAME_CYC);
  localparam int unsigned TW = cnt_w(TIMEOUT_FRAMES + 1);
  localparam logic [CW-1:0] LAST = CW'(FRAME_CYC - 1);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_FRAMES);

  if ((longint'(FRAME_CYC) <=
       longint'(MIN_CYC) + longint'(SCALE) * longint'(MAX_SPD)) ||
      (longint'(MAX_SPD) >= (longint'(1) << SPD_W))) begin : g_bad
    $error("esc_pwm_bank: illegal parameter set");
  end

  logic [CW-1:0]           cnt;
  logic [CW-1:0]           cnt_nxt;
  logic                    wrap;
  logic [NUM_CH*SPD_W-1:0] shadow;
  logic [NUM_CH*SPD_W-1:0] load_spd;
  logic [TW-1:0]           tcnt;
  logic [TW-1:0]           tcnt_nxt;
  logic                    seen;
  logic                    seen_nxt;
  logic                    fault_nxt;
  logic                    force_nxt;

  assign wrap    = (cnt == LAST);
  assign cnt_nxt = wrap ? '0 : cnt + 1'b1;

  // A write in the wrap cycle goes straight into the next frame.
  assign load_spd = wrt ? speed : shadow;

  // seen marks a frame that carried a write, so it never counts as idle.
  always_comb begin
    tcnt_nxt  = tcnt;
    seen_nxt  = seen;
    fault_nxt = fault;
    if (wrt) begin
      tcnt_nxt  = '0;
      fault_nxt = 1'b0;
      seen_nxt  = !wrap;
    end else if (wrap) begin
      seen_nxt = 1'b0;
      if (!seen) begin
        if (tcnt != TMAX) tcnt_nxt = tcnt + 1'b1;
        if (tcnt_nxt >= TMAX) fault_nxt = 1'b1;
      end
    end
  end

  assign force_nxt = !arm || fault_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt         <= LAST;
      frame_start <= 1'b0;
      shadow      <= '0;
      tcnt        <= '0;
      seen        <= 1'b1;
      fault       <= 1'b0;
    end else begin
      cnt         <= cnt_nxt;
      frame_start <= wrap;
      if (wrt) shadow <= speed;
      tcnt        <= tcnt_nxt;
      seen        <= seen_nxt;
      fault       <= fault_nxt;
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    esc_pwm_chan #(
      .SPD_W   (SPD_W),
      .MIN_CYC (MIN_CYC),
      .SCALE   (SCALE),
      .MAX_SPD (MAX_SPD),
      .CW      (CW)
    ) u_chan (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (wrap),
      .force_in (force_nxt),
      .spd_in   (load_spd[i*SPD_W +: SPD_W]),
      .cnt_nxt  (cnt_nxt),
      .pwm      (pwm[i])
    );
  end

endmodule

// File: tb/tb_esc_pwm_bank.sv
// Bench for esc_pwm_bank with shortened frames: frame-level model,
// vector table, hand sequences and random writes/arm changes.
module tb_esc_pwm_bank;

  localparam int NCH  = 4;
  localparam int SW   = 11;
  localparam int MINC = 40;
  localparam int SC   = 2;
  localparam int MAXS = 70;
  localparam int FR   = 200;
  localparam int TO   = 8;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               wrt = 1'b0;
  logic               arm = 1'b1;
  logic [NCH*SW-1:0]  speed = '0;
  logic [NCH-1:0]     pwm;
  logic               frame_start;
  logic               fault;

  esc_pwm_bank #(
    .NUM_CH(NCH), .SPD_W(SW), .MIN_CYC(MINC), .SCALE(SC),
    .MAX_SPD(MAXS), .FRAME_CYC(FR), .TIMEOUT_FRAMES(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .wrt(wrt), .speed(speed),
    .arm(arm), .pwm(pwm), .frame_start(frame_start),
    .fault(fault)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  // Frame-level model state
  int pos, fidx, last_wrt, m_fault;
  int shd[NCH];
  int cur_w[NCH];
  int hi[NCH];
  int meas[NCH];
  logic [NCH*SW-1:0] cur_spd;

  typedef struct packed {
    logic [NCH-1:0][SW-1:0] sp;
    logic                   a;
    logic [NCH-1:0][7:0]    ew;
  } vec_t;

  vec_t tab[6];

  function automatic int ref_w(int s, bit a, int f);
    if (!a || f != 0) return MINC;
    return MINC + SC * ((s > MAXS) ? MAXS : s);
  endfunction

  function automatic logic [NCH*SW-1:0] pk(int a, int b,
                                           int c, int d);
    return {SW'(d), SW'(c), SW'(b), SW'(a)};
  endfunction

  task automatic check(string name, logic [31:0] act,
                       logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail < 40)
        $display("FAIL %s: got %0d expected %0d (t=%0t)",
                 name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    pos = FR - 1;
    fidx = -1;
    last_wrt = -1;
    m_fault = 0;
    for (int i = 0; i < NCH; i++) begin
      shd[i] = 0; cur_w[i] = 0; hi[i] = 0; meas[i] = 0;
    end
  endtask

  task automatic step(bit w, logic [NCH*SW-1:0] s, bit a);
    @(negedge clk);
    wrt = w; speed = s; arm = a;
    @(posedge clk);
    if (w)
      for (int i = 0; i < NCH; i++) shd[i] = int'(s[i*SW +: SW]);
    if (pos == FR - 1) begin
      if (w) last_wrt = fidx;
      fidx++;
      pos = 0;
      if (w) m_fault = 0;
      else if (fidx - 1 - last_wrt >= TO) m_fault = 1;
      for (int i = 0; i < NCH; i++)
        cur_w[i] = ref_w(shd[i], a, m_fault);
    end else begin
      pos++;
      if (w) begin last_wrt = fidx; m_fault = 0; end
    end
    #1;
    check("frame_start", 32'(frame_start), 32'(pos == 0));
    check("fault", 32'(fault), 32'(m_fault));
    for (int i = 0; i < NCH; i++)
      check("pwm", 32'(pwm[i]), 32'(pos < cur_w[i]));
    if (pos == 0)
      for (int i = 0; i < NCH; i++) begin
        meas[i] = hi[i]; hi[i] = 0;
      end
    for (int i = 0; i < NCH; i++) if (pwm[i]) hi[i]++;
  endtask

  task automatic idle_to(int p, bit a);
    int n;
    n = 0;
    do begin
      step(1'b0, cur_spd, a);
      n++;
    end while (pos != p && n <= FR);
    check("idle_to", 32'(pos), 32'(p));
  endtask

  task automatic wr(logic [NCH*SW-1:0] s, bit a);
    cur_spd = s;
    step(1'b1, s, a);
  endtask

  initial begin
    tab[0] = '{sp: pk(0, 0, 0, 0), a: 1'b1,
               ew: {8'd40, 8'd40, 8'd40, 8'd40}};
    tab[1] = '{sp: pk(35, 70, 71, 2047), a: 1'b1,
               ew: {8'd180, 8'd180, 8'd180, 8'd110}};
    tab[2] = '{sp: pk(1, 2, 3, 4), a: 1'b1,
               ew: {8'd48, 8'd46, 8'd44, 8'd42}};
    tab[3] = '{sp: pk(10, 0, 5, 69), a: 1'b0,
               ew: {8'd40, 8'd40, 8'd40, 8'd40}};
    tab[4] = '{sp: pk(20, 50, 69, 1024), a: 1'b1,
               ew: {8'd180, 8'd178, 8'd140, 8'd80}};
    tab[5] = '{sp: pk(70, 0, 2046, 1), a: 1'b1,
               ew: {8'd42, 8'd180, 8'd40, 8'd180}};
    cur_spd = '0;
    model_reset();

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_pwm", 32'(pwm), 32'd0);
    check("rst_fs", 32'(frame_start), 32'd0);
    check("rst_fault", 32'(fault), 32'd0);
    #1 rst_n = 1'b1;
    step(1'b0, cur_spd, 1'b1);
    check("first_fs", 32'(frame_start), 32'd1);

    // Vector table: write mid-frame, measure the following frame
    for (int k = 0; k < 6; k++) begin
      idle_to(100, tab[k].a);
      wr(tab[k].sp, tab[k].a);
      idle_to(0, tab[k].a);
      idle_to(0, tab[k].a);
      for (int i = 0; i < NCH; i++)
        check($sformatf("vec%0d_ch%0d", k, i),
              32'(meas[i]), 32'(tab[k].ew[i]));
    end

    // Write during a pulse, then a write in the last frame cycle
    idle_to(100, 1'b1);
    wr(pk(35, 0, 0, 0), 1'b1);
    idle_to(0, 1'b1);
    idle_to(30, 1'b1);
    wr(pk(10, 0, 0, 0), 1'b1);
    idle_to(0, 1'b1);
    check("pulse_kept", 32'(meas[0]), 32'd110);
    idle_to(0, 1'b1);
    check("next_frame", 32'(meas[0]), 32'd60);
    idle_to(FR - 1, 1'b1);
    wr(pk(50, 0, 0, 0), 1'b1);
    idle_to(0, 1'b1);
    check("wrap_bypass", 32'(meas[0]), 32'd140);

    // Arm sampled only at the wrap
    idle_to(100, 1'b1);
    wr(pk(35, 0, 0, 0), 1'b1);
    idle_to(0, 1'b0);
    idle_to(10, 1'b0);
    idle_to(0, 1'b1);
    check("arm_low", 32'(meas[0]), 32'd40);
    idle_to(50, 1'b1);
    idle_to(0, 1'b0);
    check("arm_drop_mid", 32'(meas[0]), 32'd110);
    idle_to(0, 1'b1);
    check("arm_low2", 32'(meas[0]), 32'd40);

    // Random writes and arm changes against the model
    begin
      bit ra;
      bit w;
      logic [NCH*SW-1:0] s;
      ra = 1'b1;
      for (int c = 0; c < 5000; c++) begin
        if ($urandom_range(0, 149) == 0) ra = ~ra;
        w = ($urandom_range(0, 179) == 0);
        for (int i = 0; i < NCH; i++)
          s[i*SW +: SW] = ($urandom_range(0, 1) == 0) ?
            SW'($urandom_range(0, 90)) :
            SW'($urandom_range(0, 2047));
        if (w) cur_spd = s;
        step(w, s, ra);
      end
    end

    // Command timeout
    idle_to(100, 1'b1);
    wr(pk(35, 0, 0, 0), 1'b1);
    for (int k = 1; k <= TO + 1; k++) begin
      idle_to(0, 1'b1);
      check($sformatf("timeout_k%0d", k), 32'(fault),
            32'(k - 1 >= TO));
    end
    idle_to(0, 1'b1);
    check("fault_width", 32'(meas[0]), 32'd40);
    idle_to(77, 1'b1);
    wr(pk(35, 0, 0, 0), 1'b1);
    check("fault_clear", 32'(fault), 32'd0);
    idle_to(0, 1'b1);
    idle_to(0, 1'b1);
    check("post_fault", 32'(meas[0]), 32'd110);

    // Reset in the middle of a pulse
    idle_to(20, 1'b1);
    check("pre_rst_high", 32'(pwm[0]), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_pwm", 32'(pwm), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check("rst_hold_pwm", 32'(pwm), 32'd0);
    check("rst_hold_fs", 32'(frame_start), 32'd0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    model_reset();
    cur_spd = '0;
    step(1'b0, cur_spd, 1'b1);
    check("rst_first_fs", 32'(frame_start), 32'd1);
    idle_to(0, 1'b1);
    for (int i = 0; i < NCH; i++)
      check($sformatf("rst_w_ch%0d", i), 32'(meas[i]), 32'd40);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
